// File: rtl/video_timing_pkg.sv
// Shared constants and types for the video timing generator: default 640x480@60
// geometry, pattern encodings and the colour-bar palette.
package video_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    localparam int X_W    = 11;
    localparam int Y_W    = 10;
    localparam int PIX_W  = 24;
    localparam int N_BARS = 8;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    localparam logic [PIX_W-1:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [PIX_W-1:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [PIX_W-1:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [PIX_W-1:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [PIX_W-1:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [PIX_W-1:0] BAR_RED     = 24'hFF0000;
    localparam logic [PIX_W-1:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [PIX_W-1:0] BAR_BLACK   = 24'h000000;

    // Index N_BARS and above covers remainder pixels past the last full bar.
    function automatic logic [PIX_W-1:0] bar_color(input logic [3:0] idx);
        case (idx)
            4'd0:    return BAR_WHITE;
            4'd1:    return BAR_YELLOW;
            4'd2:    return BAR_CYAN;
            4'd3:    return BAR_GREEN;
            4'd4:    return BAR_MAGENTA;
            4'd5:    return BAR_RED;
            4'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// 24-bit parallel video source interface: run controls in, raster timing and pixels out.
interface video_timing_gen_if;
    import video_timing_pkg::*;

    logic             enable;
    logic [1:0]       pattern_sel;
    logic [PIX_W-1:0] solid_color;
    logic             vsync_out;
    logic             hsync_out;
    logic             de_out;
    logic [PIX_W-1:0] pixel_out;
    logic             frame_start;
    logic [X_W-1:0]   active_x;
    logic [Y_W-1:0]   active_y;

    modport master (
        input  enable, pattern_sel, solid_color,
        output vsync_out, hsync_out, de_out, pixel_out, frame_start, active_x, active_y
    );

    modport slave (
        output enable, pattern_sel, solid_color,
        input  vsync_out, hsync_out, de_out, pixel_out, frame_start, active_x, active_y
    );

endinterface

// File: rtl/video_timing_gen_pattern.sv
// Test-pattern source: combinational pattern mux plus a bar-width counter that
// tracks the colour-bar index without a divider.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [X_W-1:0]   i_x,
    input  logic [Y_W-1:0]   i_y,
    input  logic             i_de,
    input  pattern_e         i_pattern,
    input  logic [PIX_W-1:0] i_solid_color,
    output logic [PIX_W-1:0] o_pixel
);

    localparam int BAR_W   = (H_ACTIVE / N_BARS > 0) ? H_ACTIVE / N_BARS : 1;
    localparam int BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BAR_CW-1:0] BAR_PX_LAST = BAR_CW'(BAR_W - 1);
    localparam logic [3:0]        BAR_IDX_END = 4'(N_BARS);

    logic [BAR_CW-1:0] r_bar_px;
    logic [3:0]        r_bar_idx;
    logic              w_unused;

    // The counter is cleared during blanking so it holds (0,0) on the first active pixel.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (!i_de) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
        end else if (r_bar_px == BAR_PX_LAST) begin
            r_bar_px <= '0;
            if (r_bar_idx != BAR_IDX_END) begin
                r_bar_idx <= r_bar_idx + 4'd1;
            end
        end else begin
            r_bar_px <= r_bar_px + BAR_CW'(1);
        end
    end

    // NOTE: o_pixel gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        o_pixel = '0;
        if (i_de) begin
            unique case (i_pattern)
                PAT_BARS:  o_pixel = bar_color(r_bar_idx);
                PAT_RAMP:  o_pixel = {3{i_x[7:0]}};
                PAT_CHECK: o_pixel = (i_x[5] ^ i_y[5]) ? BAR_BLACK : BAR_WHITE;
                PAT_SOLID: o_pixel = i_solid_color;
            endcase
        end
    end

    assign w_unused = ^{i_x[X_W-1:8], i_y[Y_W-1:6], i_y[4:0]};

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, sync/de decode, per-frame pattern latch and
// the registered output stage feeding the 24-bit video interface.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK
) (
    input  logic               clock,
    input  logic               reset_n,
    video_timing_gen_if.master vif
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_CW    = $clog2(H_TOTAL + 1);
    localparam int V_CW    = $clog2(V_TOTAL + 1);

    localparam logic [H_CW-1:0] H_LAST     = H_CW'(H_TOTAL - 1);
    localparam logic [H_CW-1:0] H_SYNC_END = H_CW'(H_SYNC);
    localparam logic [H_CW-1:0] H_DE_BEG   = H_CW'(H_SYNC + H_BACK);
    localparam logic [H_CW-1:0] H_DE_END   = H_CW'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [V_CW-1:0] V_LAST     = V_CW'(V_TOTAL - 1);
    localparam logic [V_CW-1:0] V_SYNC_END = V_CW'(V_SYNC);
    localparam logic [V_CW-1:0] V_DE_BEG   = V_CW'(V_SYNC + V_BACK);
    localparam logic [V_CW-1:0] V_DE_END   = V_CW'(V_SYNC + V_BACK + V_ACTIVE);

    logic [H_CW-1:0]  r_h_cnt;
    logic [V_CW-1:0]  r_v_cnt;
    pattern_e         r_pattern;
    logic [PIX_W-1:0] r_solid;

    logic             r_vsync;
    logic             r_hsync;
    logic             r_de;
    logic [PIX_W-1:0] r_pixel;
    logic             r_frame_start;
    logic [X_W-1:0]   r_active_x;
    logic [Y_W-1:0]   r_active_y;

    logic             w_h_last;
    logic             w_v_last;
    logic             w_hsync_act;
    logic             w_vsync_act;
    logic             w_de;
    logic             w_frame_first;
    logic [X_W-1:0]   w_x;
    logic [Y_W-1:0]   w_y;
    logic [PIX_W-1:0] w_pixel;

    assign w_h_last      = (r_h_cnt == H_LAST);
    assign w_v_last      = (r_v_cnt == V_LAST);
    assign w_hsync_act   = (r_h_cnt < H_SYNC_END);
    assign w_vsync_act   = (r_v_cnt < V_SYNC_END);
    assign w_de          = (r_h_cnt >= H_DE_BEG) && (r_h_cnt < H_DE_END) &&
                           (r_v_cnt >= V_DE_BEG) && (r_v_cnt < V_DE_END);
    assign w_frame_first = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign w_x           = X_W'(r_h_cnt) - X_W'(H_SYNC + H_BACK);
    assign w_y           = Y_W'(r_v_cnt) - Y_W'(V_SYNC + V_BACK);

    // Dropping enable parks the raster at (0,0) so the next run opens a fresh frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!vif.enable) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + H_CW'(1);
            if (w_h_last) begin
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + V_CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern <= PAT_BARS;
            r_solid   <= '0;
        end else if (vif.enable && w_frame_first) begin
            r_pattern <= pattern_e'(vif.pattern_sel);
            r_solid   <= vif.solid_color;
        end
    end

    video_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_x           (w_x),
        .i_y           (w_y),
        .i_de          (w_de & vif.enable),
        .i_pattern     (r_pattern),
        .i_solid_color (r_solid),
        .o_pixel       (w_pixel)
    );

    // Output stage decodes the pre-edge count, giving one clock of latency on every output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vsync       <= 1'b1;
            r_hsync       <= 1'b1;
            r_de          <= 1'b0;
            r_pixel       <= '0;
            r_frame_start <= 1'b0;
            r_active_x    <= '0;
            r_active_y    <= '0;
        end else if (!vif.enable) begin
            r_vsync       <= 1'b1;
            r_hsync       <= 1'b1;
            r_de          <= 1'b0;
            r_pixel       <= '0;
            r_frame_start <= 1'b0;
            r_active_x    <= '0;
            r_active_y    <= '0;
        end else begin
            r_vsync       <= ~w_vsync_act;
            r_hsync       <= ~w_hsync_act;
            r_de          <= w_de;
            r_pixel       <= w_pixel;
            r_frame_start <= w_frame_first;
            r_active_x    <= w_de ? w_x : '0;
            r_active_y    <= w_de ? w_y : '0;
        end
    end

    assign vif.vsync_out   = r_vsync;
    assign vif.hsync_out   = r_hsync;
    assign vif.de_out      = r_de;
    assign vif.pixel_out   = r_pixel;
    assign vif.frame_start = r_frame_start;
    assign vif.active_x    = r_active_x;
    assign vif.active_y    = r_active_y;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Generates the raster timing (vsync, hsync, de) and a selectable test-pattern pixel stream. It is the source end of the 24-bit parallel video interface that downstream processing blocks such as the logo overlay and the HDMI encoder consume. Sync outputs are active-low, de is active-high, and all outputs are registered. Default geometry is 640x480@60 (25.175 MHz pixel clock).

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BACK, 48, back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, back porch (lines)
- clock  in  1  pixel clock; all logic is on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run when high; hold in idle when low
- pattern_sel  in  2  0 = color bars, 1 = gray ramp, 2 = checkerboard, 3 = solid
- solid_color  in  24  {R,G,B} used when pattern_sel = 3
- vsync_out  out  1  active-low vertical sync
- hsync_out  out  1  active-low horizontal sync
- de_out  out  1  active video
- pixel_out  out  24  {R[23:16],G[15:8],B[7:0]}
- frame_start  out  1  one-clock pulse marking the first clock of each frame
- active_x  out  11  active-area column; 0 when de_out = 0
- active_y  out  10  active-area row; 0 when de_out = 0

## Operation
- Totals are derived: H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT (800); V_TOTAL likewise (525).
- h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt advances when h_cnt wraps and runs 0..V_TOTAL-1, then wraps.
- Segment order, per line and per frame: sync, back porch, active, front porch. Count 0 is the first sync clock.
  - hsync is asserted (low) while h_cnt < H_SYNC.
  - vsync is asserted (low) while v_cnt < V_SYNC. Vsync edges therefore coincide with hsync falling edges.
- de is high when both conditions hold:
  - h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE)
  - v_cnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE)
- x = h_cnt - (H_SYNC+H_BACK) and y = v_cnt - (V_SYNC+V_BACK), both truncated to the port widths.
- Patterns:
  - Color bars: 8 bars, each BAR_W = H_ACTIVE/8 wide. Order is white, yellow, cyan, green, magenta, red, blue, black, each component 0xFF or 0x00. The bar index comes from a bar-width counter, with no divider. Any remainder pixels (when H_ACTIVE is not divisible by 8) are black.
  - Gray ramp: R = G = B = x[7:0].
  - Checkerboard: 32x32 squares. 0xFFFFFF when x[5]^y[5] = 0, otherwise 0x000000.
  - Solid: solid_color.
- pattern_sel and solid_color are sampled only on the frame's first clock (h_cnt = 0, v_cnt = 0). Changes made mid-frame take effect from the next frame.
- pixel_out is 0x000000 whenever de_out = 0.
- enable low:
  - counters are held at 0
  - vsync_out and hsync_out are 1, de_out is 0, pixel_out is 0, frame_start is 0
  - when enable returns high, a frame starts at h_cnt = 0, v_cnt = 0
  - enable is synchronous; deassertion mid-line truncates that line immediately

## Timing
- Reset values: vsync_out = 1, hsync_out = 1, de_out = 0, pixel_out = 0, frame_start = 0, active_x = 0, active_y = 0, counters = 0, latched pattern = 0.
- Latency is one clock: counter state at edge N is reflected on the outputs after edge N+1. All outputs are mutually aligned.
- The first clock edge with reset_n = 1 and enable = 1 registers count (0,0). Immediately after that edge, vsync_out = 0, hsync_out = 0 and frame_start = 1.
- frame_start is high for exactly one clock per frame, aligned with the vsync_out falling edge.
- Line period is H_TOTAL clocks. Frame period is H_TOTAL*V_TOTAL clocks (420000 at the defaults).
- Reset asserted mid-frame forces the reset values asynchronously. Restart follows the first-frame rule above.

## Structure
- Shared package video_timing_pkg holds:
  - the default 640x480@60 timing constants
  - the 8 color-bar constants
  - the pattern_sel encodings
- One sub-module, video_pattern_gen, is natural. It is a combinational pattern mux plus the bar-width counter, taking (x, y, de, pattern, solid_color) and producing pixel. The top level owns the counters, the sync decode and the output registers.

## Test plan
- Reset behaviour: hold reset_n low for 5 clocks, checking all outputs at their reset values. Release with enable = 1 → frame_start, hsync_out = 0 and vsync_out = 0 one edge later.
- Line and frame geometry, defaults, 2 full frames measured:
  - hsync low 96 of every 800 clocks
  - vsync low for 1600 clocks
  - de high 640 clocks per line on 480 lines
  - first de 144 clocks after each hsync fall, on line 35
  - frame_start every 420000 clocks
- Color bars: with pattern_sel = 0, active line 0 gives x = 0..79 → 0xFFFFFF, x = 80 → 0xFFFF00, x = 560 → 0x000000. pixel_out = 0 outside de.
- Pattern latching: switch pattern_sel 0 → 3 with solid_color = 0x123456 mid-frame → bars continue to the end of the frame, then 0x123456 from the next frame's first de.
- Gray ramp and checkerboard:
  - ramp: x = 300 → 0x2C2C2C
  - checkerboard: (x = 32, y = 0) → 0x000000; (32, 32) → 0xFFFFFF
- enable and async reset: deassert enable at x = 100 on line 50 → next clock de_out = 0 and syncs high, and the first frame_start appears one edge after enable returns high. Repeat with reset_n pulsed low for one half-cycle mid-line → outputs go to reset values asynchronously, and the same restart rule applies.
